// File: rtl/proc_pkg.sv
// Shared ISA constants, rstatus codes and the memory-stage FSM state type.
package proc_pkg;

   // Opcodes in ins[31:27]
   localparam logic [4:0] OP_RTYPE = 5'b00000;
   localparam logic [4:0] OP_ADDI  = 5'b00101;
   localparam logic [4:0] OP_SW    = 5'b00111;
   localparam logic [4:0] OP_LW    = 5'b01000;

   // ALU ops in ins[6:2] for R-type instructions
   localparam logic [4:0] ALU_ADD = 5'b00000;
   localparam logic [4:0] ALU_SUB = 5'b00001;
   localparam logic [4:0] ALU_MUL = 5'b00110;
   localparam logic [4:0] ALU_DIV = 5'b00111;

   // rstatus codes written on arithmetic overflow
   localparam logic [31:0] RSTATUS_ADD  = 32'd1;
   localparam logic [31:0] RSTATUS_ADDI = 32'd2;
   localparam logic [31:0] RSTATUS_SUB  = 32'd3;
   localparam logic [31:0] RSTATUS_MUL  = 32'd4;
   localparam logic [31:0] RSTATUS_DIV  = 32'd5;
   localparam logic [4:0]  RSTATUS_REG  = 5'd30;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } mwState_e;

   // True for opcodes that access data memory
   function automatic logic isMemOp(input logic [4:0] op);
      return (op == OP_LW) || (op == OP_SW);
   endfunction

endpackage

// File: rtl/dffe_ref.sv
// Single-bit register with synchronous active-high reset and load enable.
module dffe_ref (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic d,
   output logic q
);

   // Reset clears the bit; otherwise load when enabled, else hold
   always_ff @(posedge clk) begin
      if (reset) begin
         q <= 1'b0;
      end else if (en) begin
         q <= d;
      end else begin
         q <= q;
      end
   end

endmodule

// File: rtl/ovf_rewrite.sv
// Turns an overflowing add/addi/sub/mul/div into a write of its rstatus code
// to the rstatus register; everything else passes through untouched.
module ovf_rewrite
   import proc_pkg::*;
(
   input  logic [31:0] ins,
   input  logic [31:0] o,
   input  logic        ovf,
   output logic [31:0] insOut,
   output logic [31:0] oOut
);

   logic [4:0]  opcode_s;
   logic [4:0]  aluOp_s;
   logic        hit_s;
   logic [31:0] code_s;

   assign opcode_s = ins[31:27];
   assign aluOp_s  = ins[6:2];

   // Pick the rstatus code for arithmetic ops that can overflow
   always_comb begin
      hit_s  = 1'b0;
      code_s = 32'd0;
      if (opcode_s == OP_ADDI) begin
         hit_s  = 1'b1;
         code_s = RSTATUS_ADDI;
      end else if (opcode_s == OP_RTYPE) begin
         case (aluOp_s)
            ALU_ADD: begin hit_s = 1'b1; code_s = RSTATUS_ADD; end
            ALU_SUB: begin hit_s = 1'b1; code_s = RSTATUS_SUB; end
            ALU_MUL: begin hit_s = 1'b1; code_s = RSTATUS_MUL; end
            ALU_DIV: begin hit_s = 1'b1; code_s = RSTATUS_DIV; end
            default: begin hit_s = 1'b0; code_s = 32'd0; end
         endcase
      end else begin
         hit_s  = 1'b0;
         code_s = 32'd0;
      end
   end

   // Apply the rewrite: rd becomes rstatus, result becomes the code
   always_comb begin
      insOut = ins;
      oOut   = o;
      if (ovf && hit_s) begin
         insOut[26:22] = RSTATUS_REG;
         oOut          = code_s;
      end else begin
         insOut = ins;
         oOut   = o;
      end
   end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory stage and MW pipeline register: issues data-memory accesses over a
// req/ack handshake, stalls upstream while an access is outstanding, and
// registers the (possibly overflow-rewritten) result for writeback.
module mem_wb_stage
   import proc_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        valid_in,
   input  logic [31:0] o_in,
   input  logic [31:0] b_in,
   input  logic [31:0] ins_in,
   input  logic        ovf_in,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        stall_out,
   output logic        valid_out,
   output logic [31:0] o_out,
   output logic [31:0] d_out,
   output logic [31:0] ins_out
);

   mwState_e    state_r;
   mwState_e    nextState_s;
   logic        memOp_s;
   logic        isLoad_s;
   logic        isStore_s;
   logic        req_s;
   logic        stall_s;
   logic        commit_s;
   logic        mwEn_s;
   logic        dEn_s;
   logic [31:0] rwIns_s;
   logic [31:0] rwO_s;
   logic [64:0] mwD_s;
   logic [64:0] mwQ_r;
   logic [31:0] dQ_r;

   assign memOp_s   = valid_in & isMemOp(ins_in[31:27]);
   assign isLoad_s  = valid_in & (ins_in[31:27] == OP_LW);
   assign isStore_s = valid_in & (ins_in[31:27] == OP_SW);

   ovf_rewrite u_ovfRewrite (
      .ins    (ins_in),
      .o      (o_in),
      .ovf    (valid_in & ovf_in),
      .insOut (rwIns_s),
      .oOut   (rwO_s)
   );

   // FSM state register; reset abandons any outstanding access
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= nextState_s;
      end
   end

   // Next state, request, stall and commit decisions
   always_comb begin
      nextState_s = state_r;
      req_s       = 1'b0;
      stall_s     = 1'b0;
      commit_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (memOp_s) begin
               req_s = 1'b1;
               if (dmem_ack) begin
                  commit_s = 1'b1;
               end else begin
                  stall_s     = 1'b1;
                  nextState_s = ST_WAIT;
               end
            end else begin
               commit_s = 1'b1;
            end
         end
         ST_WAIT: begin
            req_s = 1'b1;
            if (dmem_ack) begin
               commit_s    = 1'b1;
               nextState_s = ST_IDLE;
            end else begin
               stall_s = 1'b1;
            end
         end
         default: begin
            nextState_s = ST_IDLE;
         end
      endcase
   end

   // MW next value: the instruction on commit, otherwise a bubble
   always_comb begin
      mwD_s = {1'b0, o_in, 32'd0};
      if (commit_s && valid_in) begin
         mwD_s = {1'b1, rwO_s, rwIns_s};
      end else begin
         mwD_s = {1'b0, o_in, 32'd0};
      end
   end

   // MW loads in IDLE (instruction or stall bubble) and on the WAIT ack cycle
   assign mwEn_s = ~stall_s | (state_r == ST_IDLE);
   assign dEn_s  = commit_s & isLoad_s;

   for (genvar i = 0; i < 65; i++) begin : g_mwReg
      dffe_ref u_bit (
         .clk   (clk),
         .reset (reset),
         .en    (mwEn_s),
         .d     (mwD_s[i]),
         .q     (mwQ_r[i])
      );
   end

   for (genvar i = 0; i < 32; i++) begin : g_dReg
      dffe_ref u_bit (
         .clk   (clk),
         .reset (reset),
         .en    (dEn_s),
         .d     (dmem_rdata[i]),
         .q     (dQ_r[i])
      );
   end

   assign dmem_req   = req_s;
   assign dmem_we    = req_s & isStore_s;
   assign dmem_addr  = o_in;
   assign dmem_wdata = b_in;
   assign stall_out  = stall_s;
   assign valid_out  = mwQ_r[64];
   assign o_out      = mwQ_r[63:32];
   assign ins_out    = mwQ_r[31:0];
   assign d_out      = dQ_r;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage.
module tb_mem_wb_stage;

   logic        clk;
   logic        reset;
   logic        valid_in;
   logic [31:0] o_in;
   logic [31:0] b_in;
   logic [31:0] ins_in;
   logic        ovf_in;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;
   logic        stall_out;
   logic        valid_out;
   logic [31:0] o_out;
   logic [31:0] d_out;
   logic [31:0] ins_out;

   int passCount  = 0;
   int checkCount = 0;

   // Hand-encoded instructions: opcode[31:27] rd[26:22] rs[21:17] rt[16:12] aluop[6:2]
   localparam logic [31:0] INS_ADD_RD5  = 32'h0142_2000;
   localparam logic [31:0] INS_ADD_RW   = 32'h0782_2000;
   localparam logic [31:0] INS_LW_RD3   = 32'h40C0_0000;
   localparam logic [31:0] INS_SW       = 32'h3900_0000;
   localparam logic [31:0] INS_ADDI_RD6 = 32'h2980_0000;

   mem_wb_stage dut (
      .clk        (clk),
      .reset      (reset),
      .valid_in   (valid_in),
      .o_in       (o_in),
      .b_in       (b_in),
      .ins_in     (ins_in),
      .ovf_in     (ovf_in),
      .dmem_req   (dmem_req),
      .dmem_we    (dmem_we),
      .dmem_addr  (dmem_addr),
      .dmem_wdata (dmem_wdata),
      .dmem_ack   (dmem_ack),
      .dmem_rdata (dmem_rdata),
      .stall_out  (stall_out),
      .valid_out  (valid_out),
      .o_out      (o_out),
      .d_out      (d_out),
      .ins_out    (ins_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idleInputs();
      valid_in   = 1'b0;
      o_in       = 32'd0;
      b_in       = 32'd0;
      ins_in     = 32'd0;
      ovf_in     = 1'b0;
      dmem_ack   = 1'b0;
      dmem_rdata = 32'd0;
   endtask

   task automatic test_reset();
      idleInputs();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      #1;
      checkCount++;
      if ({valid_out, o_out, d_out, ins_out} !== 97'd0) $display("FAIL reset_regs: got v=%0b o=%h d=%h ins=%h, expected all 0", valid_out, o_out, d_out, ins_out);
      else passCount++;
      checkCount++;
      if ({dmem_req, stall_out} !== 2'b00) $display("FAIL reset_req_stall: got req=%0b stall=%0b, expected 0 0", dmem_req, stall_out);
      else passCount++;
   endtask

   task automatic test_ovf_rewrite();
      logic [31:0] insTab [6];
      logic [31:0] oExp   [6];
      logic [31:0] insExp [6];
      insTab[0] = INS_ADD_RD5;  oExp[0] = 32'd1;        insExp[0] = INS_ADD_RW;
      insTab[1] = 32'h01C0_0004; oExp[1] = 32'd3;       insExp[1] = 32'h0780_0004;
      insTab[2] = INS_ADDI_RD6; oExp[2] = 32'd2;        insExp[2] = 32'h2F80_0000;
      insTab[3] = 32'h0140_0018; oExp[3] = 32'd4;       insExp[3] = 32'h0780_0018;
      insTab[4] = 32'h0140_001C; oExp[4] = 32'd5;       insExp[4] = 32'h0780_001C;
      insTab[5] = 32'h0140_0008; oExp[5] = 32'h8000_0000; insExp[5] = 32'h0140_0008;
      for (int i = 0; i < 6; i++) begin
         valid_in = 1'b1;
         ins_in   = insTab[i];
         o_in     = 32'h8000_0000;
         ovf_in   = 1'b1;
         #1;
         checkCount++;
         if ({dmem_req, stall_out} !== 2'b00) $display("FAIL ovf_noreq[%0d]: got req=%0b stall=%0b, expected 0 0", i, dmem_req, stall_out);
         else passCount++;
         tick();
         checkCount++;
         if ({valid_out, o_out, ins_out} !== {1'b1, oExp[i], insExp[i]}) $display("FAIL ovf_rewrite[%0d]: got v=%0b o=%h ins=%h, expected v=1 o=%h ins=%h", i, valid_out, o_out, ins_out, oExp[i], insExp[i]);
         else passCount++;
      end
      idleInputs();
   endtask

   task automatic test_zero_wait_load();
      valid_in   = 1'b1;
      ins_in     = INS_LW_RD3;
      o_in       = 32'h0000_0010;
      ovf_in     = 1'b1;
      dmem_ack   = 1'b1;
      dmem_rdata = 32'hDEAD_BEEF;
      #1;
      checkCount++;
      if ({dmem_req, dmem_we, stall_out, dmem_addr} !== {3'b100, 32'h0000_0010}) $display("FAIL zw_load_req: got req=%0b we=%0b stall=%0b addr=%h, expected 1 0 0 00000010", dmem_req, dmem_we, stall_out, dmem_addr);
      else passCount++;
      tick();
      checkCount++;
      if ({valid_out, o_out, d_out, ins_out} !== {1'b1, 32'h0000_0010, 32'hDEAD_BEEF, INS_LW_RD3}) $display("FAIL zw_load_mw: got v=%0b o=%h d=%h ins=%h, expected v=1 o=00000010 d=deadbeef ins=%h", valid_out, o_out, d_out, ins_out, INS_LW_RD3);
      else passCount++;
      idleInputs();
      dmem_rdata = 32'h1234_5678;
      tick();
      checkCount++;
      if ({valid_out, d_out} !== {1'b0, 32'hDEAD_BEEF}) $display("FAIL d_hold: got v=%0b d=%h, expected v=0 d=deadbeef", valid_out, d_out);
      else passCount++;
   endtask

   task automatic test_store_wait();
      valid_in = 1'b1;
      ins_in   = INS_SW;
      o_in     = 32'h0000_0020;
      b_in     = 32'h0000_0055;
      for (int c = 0; c < 3; c++) begin
         #1;
         checkCount++;
         if ({stall_out, dmem_req, dmem_we, dmem_addr, dmem_wdata} !== {3'b111, 32'h0000_0020, 32'h0000_0055}) $display("FAIL sw_wait_bus[%0d]: got stall=%0b req=%0b we=%0b addr=%h wdata=%h, expected 1 1 1 00000020 00000055", c, stall_out, dmem_req, dmem_we, dmem_addr, dmem_wdata);
         else passCount++;
         tick();
         checkCount++;
         if ({valid_out, ins_out} !== {1'b0, 32'd0}) $display("FAIL sw_wait_bubble[%0d]: got v=%0b ins=%h, expected v=0 ins=0", c, valid_out, ins_out);
         else passCount++;
      end
      dmem_ack = 1'b1;
      #1;
      checkCount++;
      if ({stall_out, dmem_req, dmem_we} !== 3'b011) $display("FAIL sw_ack_cycle: got stall=%0b req=%0b we=%0b, expected 0 1 1", stall_out, dmem_req, dmem_we);
      else passCount++;
      tick();
      checkCount++;
      if ({valid_out, o_out, ins_out, d_out} !== {1'b1, 32'h0000_0020, INS_SW, 32'hDEAD_BEEF}) $display("FAIL sw_retire: got v=%0b o=%h ins=%h d=%h, expected v=1 o=00000020 ins=%h d=deadbeef", valid_out, o_out, ins_out, d_out, INS_SW);
      else passCount++;
      idleInputs();
   endtask

   task automatic test_reset_mid_wait();
      valid_in = 1'b1;
      ins_in   = INS_LW_RD3;
      o_in     = 32'h0000_0040;
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      idleInputs();
      #1;
      checkCount++;
      if ({valid_out, o_out, d_out, ins_out, dmem_req, stall_out} !== 99'd0) $display("FAIL rst_wait_outputs: got v=%0b o=%h d=%h ins=%h req=%0b stall=%0b, expected all 0", valid_out, o_out, d_out, ins_out, dmem_req, stall_out);
      else passCount++;
      dmem_ack   = 1'b1;
      dmem_rdata = 32'h1111_1111;
      tick();
      checkCount++;
      if ({valid_out, d_out, ins_out} !== 65'd0) $display("FAIL late_ack: got v=%0b d=%h ins=%h, expected all 0", valid_out, d_out, ins_out);
      else passCount++;
      dmem_ack = 1'b0;
      valid_in = 1'b1;
      ins_in   = INS_ADDI_RD6;
      o_in     = 32'h0000_0003;
      #1;
      checkCount++;
      if (stall_out !== 1'b0) $display("FAIL rst_idle_stall: got %0b, expected 0", stall_out);
      else passCount++;
      tick();
      checkCount++;
      if ({valid_out, o_out, ins_out} !== {1'b1, 32'h0000_0003, INS_ADDI_RD6}) $display("FAIL rst_idle_commit: got v=%0b o=%h ins=%h, expected v=1 o=00000003 ins=%h", valid_out, o_out, ins_out, INS_ADDI_RD6);
      else passCount++;
      idleInputs();
   endtask

   task automatic test_back_to_back();
      valid_in = 1'b1;
      ins_in   = INS_LW_RD3;
      o_in     = 32'h0000_0030;
      #1;
      checkCount++;
      if (stall_out !== 1'b1) $display("FAIL b2b_lw_stall: got %0b, expected 1", stall_out);
      else passCount++;
      tick();
      checkCount++;
      if (valid_out !== 1'b0) $display("FAIL b2b_bubble: got v=%0b, expected 0", valid_out);
      else passCount++;
      dmem_ack   = 1'b1;
      dmem_rdata = 32'hCAFE_0001;
      tick();
      checkCount++;
      if ({valid_out, ins_out, d_out} !== {1'b1, INS_LW_RD3, 32'hCAFE_0001}) $display("FAIL b2b_lw: got v=%0b ins=%h d=%h, expected v=1 ins=%h d=cafe0001", valid_out, ins_out, d_out, INS_LW_RD3);
      else passCount++;
      ins_in     = INS_ADDI_RD6;
      o_in       = 32'h0000_0077;
      dmem_rdata = 32'hBAD0_BAD0;
      #1;
      checkCount++;
      if ({dmem_req, stall_out} !== 2'b00) $display("FAIL b2b_addi_req: got req=%0b stall=%0b, expected 0 0", dmem_req, stall_out);
      else passCount++;
      tick();
      checkCount++;
      if ({valid_out, o_out, ins_out, d_out} !== {1'b1, 32'h0000_0077, INS_ADDI_RD6, 32'hCAFE_0001}) $display("FAIL b2b_addi: got v=%0b o=%h ins=%h d=%h, expected v=1 o=00000077 ins=%h d=cafe0001", valid_out, o_out, ins_out, d_out, INS_ADDI_RD6);
      else passCount++;
      ins_in = INS_SW;
      o_in   = 32'h0000_0088;
      b_in   = 32'h0000_0099;
      #1;
      checkCount++;
      if ({dmem_req, dmem_we, stall_out, dmem_wdata} !== {3'b110, 32'h0000_0099}) $display("FAIL b2b_sw_req: got req=%0b we=%0b stall=%0b wdata=%h, expected 1 1 0 00000099", dmem_req, dmem_we, stall_out, dmem_wdata);
      else passCount++;
      tick();
      checkCount++;
      if ({valid_out, o_out, ins_out} !== {1'b1, 32'h0000_0088, INS_SW}) $display("FAIL b2b_sw: got v=%0b o=%h ins=%h, expected v=1 o=00000088 ins=%h", valid_out, o_out, ins_out, INS_SW);
      else passCount++;
      idleInputs();
   endtask

   task automatic test_bubble_ovf();
      valid_in = 1'b0;
      ovf_in   = 1'b1;
      ins_in   = INS_ADD_RD5;
      o_in     = 32'h0000_ABCD;
      #1;
      checkCount++;
      if ({dmem_req, stall_out} !== 2'b00) $display("FAIL bubble_req: got req=%0b stall=%0b, expected 0 0", dmem_req, stall_out);
      else passCount++;
      tick();
      checkCount++;
      if ({valid_out, ins_out, o_out} !== {1'b0, 32'd0, 32'h0000_ABCD}) $display("FAIL bubble_ovf: got v=%0b ins=%h o=%h, expected v=0 ins=0 o=0000abcd", valid_out, ins_out, o_out);
      else passCount++;
      idleInputs();
   endtask

   initial begin
      test_reset();
      test_ovf_rewrite();
      test_zero_wait_load();
      test_store_wait();
      test_reset_mid_wait();
      test_back_to_back();
      test_bubble_ovf();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
